sha256_core_arbiter: RTL and testbench
======================================

# sha256_core_arbiter

Shares one SHA-256 engine (padding/pre-processing, message schedule and compression) among NUM_REQ requesting cores. Accepts 128-bit messages over per-requester valid/ready ports, grants them round-robin, drives the engine's 128-bit message input and start strobe, and waits for completion. It then returns the 256-bit digest to the granted requester over a valid/ready response port. Sits between the core-side fabric and the pre-processing stage of the multicore design.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- TIMEOUT_CYCLES, 255, watchdog limit in cycles; used only when the watchdog is compiled in
- clk_i  input  1  clock, all state on rising edge
- reset_i  input  1  asynchronous, active-high reset
- req_v_i  input  NUM_REQ  per-requester message valid
- req_msg_i  input  NUM_REQ*128  message of requester k in bits [128k+127:128k]
- req_ready_o  output  NUM_REQ  one-hot accept; at most one bit set
- msg_o  output  128  registered message to pre-processing
- eng_start_o  output  1  one-cycle start pulse to engine
- eng_done_i  input  1  engine completion pulse; digest valid in same cycle
- eng_digest_i  input  256  engine digest
- resp_v_o  output  NUM_REQ  one-hot response valid to the granted requester
- resp_digest_o  output  256  registered digest
- resp_ready_i  input  NUM_REQ  per-requester response ready
- busy_o  output  1  high in every state except IDLE

## Operation
- FSM states: IDLE, START, BUSY, RESP.
- IDLE: the arbiter selects the first requester with req_v_i set, scanning from index ptr+1 upward and wrapping modulo NUM_REQ. req_ready_o is set combinationally for that requester only. On handshake: latch req_msg_i into msg_o and the index into grant_id, set ptr to grant_id, and go to START. With no valid requests, stay in IDLE with req_ready_o = 0.
- START: eng_start_o = 1 for exactly one cycle, then go to BUSY. eng_done_i is ignored in START.
- BUSY: on eng_done_i, capture eng_digest_i into resp_digest_o and go to RESP. req_ready_o stays 0 throughout.
- RESP: resp_v_o[grant_id] = 1 and resp_digest_o is held stable. Ready bits of other requesters are ignored. On resp_ready_i[grant_id], go to IDLE.
- New requests are never accepted in START, BUSY or RESP; the design has no queueing.
- msg_o holds its value from grant until the next grant.
- Reset values: state IDLE, ptr = NUM_REQ-1 (so requester 0 has highest initial priority), grant_id 0, msg_o 0, resp_digest_o 0, and every output strobe and valid 0.
- Reset mid-operation: return to IDLE at once. The in-flight message is dropped, and a later eng_done_i is ignored because it arrives in IDLE.

## Timing
- Request handshake at cycle T gives eng_start_o high at T+1, with msg_o valid from T+1.
- eng_done_i at cycle D (D ≥ T+2) gives resp_v_o high from D+1.
- resp_ready_i handshake at cycle R returns the FSM to IDLE at R+1. The earliest next grant is at R+1, so there is no bubble beyond one cycle.
- Minimum turnaround, request to response valid, with a 1-cycle engine: 3 cycles.
- Requesters must keep req_v_i and req_msg_i stable until they see ready. Dropping valid without a handshake is legal; the grant then moves to the next valid requester in the same cycle.

## Configuration
- Macro: SHA256_ARB_WATCHDOG_EN.
- When defined: a counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to BUSY and increments every BUSY cycle. If it reaches TIMEOUT_CYCLES without eng_done_i, the FSM goes to RESP with resp_digest_o = 0 and the output timeout_o (1 bit, reset 0) is asserted alongside resp_v_o. If eng_done_i arrives in the same cycle the limit is reached, done wins.
- When not defined: no counter, no timeout_o port, and BUSY waits indefinitely.

## Structure
- Shared package sha256_pkg holds:
  - MSG_W = 128 and DIGEST_W = 256
  - the state enum (IDLE, START, BUSY, RESP)
  - the requester index width helper
- Sub-module sha256_rr_arbiter: combinational rotating-priority select with inputs req vector and ptr, and outputs a one-hot grant and an encoded index. The FSM and datapath registers stay in the top module.

## Test plan
- Single request: req_v_i = 4'b0010, msg 0x61626300…; engine done 5 cycles after start with digest 0xBA7816BF… -> eng_start_o one pulse at T+1, msg_o matches, resp_v_o = 4'b0010 at D+1, digest matches.
- All four requesters valid continuously, engine latency 3 -> grant order 0, 1, 2, 3, 0, …; no requester granted twice before all others have been served.
- Backpressure: resp_ready_i low for 10 cycles in RESP -> resp_v_o and resp_digest_o stable, req_ready_o = 0 throughout, no eng_start_o.
- Stray signals: eng_done_i pulsed in IDLE and in START -> ignored, no state change. resp_ready_i on a non-granted index -> ignored.
- Reset asserted in BUSY, then done pulsed after release -> all outputs 0 during reset and after, no response issued; next request starts from requester 0 priority.
- With SHA256_ARB_WATCHDOG_EN, TIMEOUT_CYCLES = 8, engine never done -> resp_v_o and timeout_o high 9 cycles after entering BUSY, digest 0.

Source files
------------

// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared widths, FSM state enum and index-width helper for the SHA-256 arbiter
package sha256_pkg;

  localparam int MSG_W    = 128;
  localparam int DIGEST_W = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sha256_core_arbiter_if.sv
// rtl/sha256_core_arbiter_if.sv - requester, engine and response bundle of the SHA-256 arbiter
// timeout_o exists only when SHA256_ARB_WATCHDOG_EN is defined.
interface sha256_core_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import sha256_pkg::*;

  logic [NUM_REQ-1:0]       req_v_i;
  logic [NUM_REQ*MSG_W-1:0] req_msg_i;
  logic [NUM_REQ-1:0]       req_ready_o;
  logic [MSG_W-1:0]         msg_o;
  logic                     eng_start_o;
  logic                     eng_done_i;
  logic [DIGEST_W-1:0]      eng_digest_i;
  logic [NUM_REQ-1:0]       resp_v_o;
  logic [DIGEST_W-1:0]      resp_digest_o;
  logic [NUM_REQ-1:0]       resp_ready_i;
  logic                     busy_o;
`ifdef SHA256_ARB_WATCHDOG_EN
  logic                     timeout_o;
`endif

  modport slave (
    input  req_v_i, req_msg_i, eng_done_i, eng_digest_i, resp_ready_i,
    output
`ifdef SHA256_ARB_WATCHDOG_EN
           timeout_o,
`endif
           req_ready_o, msg_o, eng_start_o, resp_v_o, resp_digest_o, busy_o
  );

  modport master (
    output req_v_i, req_msg_i, eng_done_i, eng_digest_i, resp_ready_i,
    input
`ifdef SHA256_ARB_WATCHDOG_EN
          timeout_o,
`endif
          req_ready_o, msg_o, eng_start_o, resp_v_o, resp_digest_o, busy_o
  );

endinterface

// File: rtl/sha256_rr_arbiter.sv
// rtl/sha256_rr_arbiter.sv - combinational rotating-priority select, scanning upward from ptr_i+1
module sha256_rr_arbiter
  import sha256_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  logic [IDX_W-1:0] cand;

  // Offset NUM_REQ wraps back to ptr_i itself, so the last owner is served last.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(ptr_i) + i) % NUM_REQ);
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/sha256_core_arbiter.sv
// rtl/sha256_core_arbiter.sv - round-robin sharing of one SHA-256 engine among NUM_REQ cores
// Optional engine watchdog with timeout_o: define SHA256_ARB_WATCHDOG_EN.
module sha256_core_arbiter
  import sha256_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                  clk_i,
  input logic                  reset_i,
  sha256_core_arbiter_if.slave bus
);

  localparam int IDX_W = idx_width(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("sha256_core_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    grant_id_q, grant_id_d;
  logic [MSG_W-1:0]    msg_q, msg_d;
  logic [DIGEST_W-1:0] digest_q, digest_d;

  logic [NUM_REQ-1:0]  rr_gnt;
  logic [IDX_W-1:0]    rr_idx;
  logic                rr_any;
  logic [MSG_W-1:0]    msg_sel;

`ifdef SHA256_ARB_WATCHDOG_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                timeout_q, timeout_d;
`endif

  sha256_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i (bus.req_v_i),
    .ptr_i (ptr_q),
    .gnt_o (rr_gnt),
    .idx_o (rr_idx),
    .any_o (rr_any)
  );

  always_comb begin
    msg_sel = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (rr_idx == IDX_W'(k)) msg_sel = bus.req_msg_i[k*MSG_W +: MSG_W];
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      ptr_q      <= IDX_W'(NUM_REQ - 1);
      grant_id_q <= '0;
      msg_q      <= '0;
      digest_q   <= '0;
`ifdef SHA256_ARB_WATCHDOG_EN
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_id_q <= grant_id_d;
      msg_q      <= msg_d;
      digest_q   <= digest_d;
`ifdef SHA256_ARB_WATCHDOG_EN
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  // Valid is the only handshake qualifier in IDLE: the selected requester is ready by construction.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_id_d = grant_id_q;
    msg_d      = msg_q;
    digest_d   = digest_q;
`ifdef SHA256_ARB_WATCHDOG_EN
    cnt_d      = cnt_q;
    timeout_d  = timeout_q;
`endif
    case (state_q)
      IDLE: begin
        if (rr_any) begin
          msg_d      = msg_sel;
          grant_id_d = rr_idx;
          ptr_d      = rr_idx;
          state_d    = START;
        end
      end
      START: begin
        state_d = BUSY;
`ifdef SHA256_ARB_WATCHDOG_EN
        cnt_d   = '0;
`endif
      end
      BUSY: begin
        if (bus.eng_done_i) begin
          digest_d  = bus.eng_digest_i;
          state_d   = RESP;
`ifdef SHA256_ARB_WATCHDOG_EN
          timeout_d = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
          digest_d  = '0;
          timeout_d = 1'b1;
          state_d   = RESP;
        end else begin
          cnt_d     = cnt_q + 1'b1;
`endif
        end
      end
      RESP: begin
        if (bus.resp_ready_i[grant_id_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready_o   = (state_q == IDLE) ? rr_gnt : '0;
    bus.eng_start_o   = (state_q == START);
    bus.resp_v_o      = (state_q == RESP) ? (NUM_REQ'(1) << grant_id_q) : '0;
    bus.busy_o        = (state_q != IDLE);
    bus.msg_o         = msg_q;
    bus.resp_digest_o = digest_q;
`ifdef SHA256_ARB_WATCHDOG_EN
    bus.timeout_o     = timeout_q && (state_q == RESP);
`endif
  end

endmodule

// File: tb/tb_sha256_core_arbiter.sv
// tb/tb_sha256_core_arbiter.sv - table-driven check of grant order, engine timing, backpressure and reset
module tb_sha256_core_arbiter;
  import sha256_pkg::*;

  localparam int N = 4;
  localparam logic [255:0] DIG_ABC =
    256'hBA7816BF8F01CFEA414140DE5DAE2223B00361A396177A9CB410FF61F20015AD;

  logic clk_i = 1'b0;
  logic reset_i;
  always #5 clk_i = ~clk_i;

  sha256_core_arbiter_if #(.NUM_REQ(N)) bus ();

  sha256_core_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(8)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  typedef struct {
    logic [N-1:0]  req_v;
    int            lat;
    int            bp;
    int            exp_id;
    logic [255:0]  dig;
  } vec_t;

  vec_t vecs[9];
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [127:0] msg_of(input int k);
    return {32'h61626300 | 32'(k), 64'h0, 32'h00000018};
  endfunction

  task automatic run_txn(input vec_t v);
    logic [N-1:0] oh;
    oh = N'(1) << v.exp_id;
    bus.req_v_i = v.req_v;
    #1;
    chk("req_ready", 256'(bus.req_ready_o), 256'(oh));
    cyc();
    chk("eng_start", 256'(bus.eng_start_o), 256'(1));
    chk("msg_o", 256'(bus.msg_o), 256'(msg_of(v.exp_id)));
    chk("ready_start", 256'(bus.req_ready_o), 256'(0));
    for (int i = 0; i < v.lat; i++) begin
      cyc();
      chk("eng_start_busy", 256'(bus.eng_start_o), 256'(0));
      chk("ready_busy", 256'(bus.req_ready_o), 256'(0));
      chk("resp_v_busy", 256'(bus.resp_v_o), 256'(0));
    end
    bus.eng_done_i   = 1'b1;
    bus.eng_digest_i = v.dig;
    cyc();
    bus.eng_done_i   = 1'b0;
    bus.eng_digest_i = ~v.dig;
    chk("resp_v", 256'(bus.resp_v_o), 256'(oh));
    chk("resp_digest", bus.resp_digest_o, v.dig);
    bus.resp_ready_i = ~oh;
    for (int i = 0; i < v.bp; i++) begin
      cyc();
      chk("bp_resp_v", 256'(bus.resp_v_o), 256'(oh));
      chk("bp_digest", bus.resp_digest_o, v.dig);
      chk("bp_ready", 256'(bus.req_ready_o), 256'(0));
      chk("bp_start", 256'(bus.eng_start_o), 256'(0));
    end
    bus.resp_ready_i = oh;
    cyc();
    bus.resp_ready_i = '0;
    chk("idle_busy", 256'(bus.busy_o), 256'(0));
    chk("idle_resp_v", 256'(bus.resp_v_o), 256'(0));
  endtask

  initial begin
    vecs[0] = '{4'b0010, 5, 0,  1, DIG_ABC};
    vecs[1] = '{4'b1111, 3, 0,  2, 256'h0};
    vecs[2] = '{4'b1111, 3, 0,  3, 256'h0};
    vecs[3] = '{4'b1111, 3, 0,  0, 256'h0};
    vecs[4] = '{4'b1111, 3, 0,  1, 256'h0};
    vecs[5] = '{4'b1111, 3, 0,  2, 256'h0};
    vecs[6] = '{4'b1001, 1, 10, 3, 256'h0};
    vecs[7] = '{4'b1001, 1, 0,  0, 256'h0};
    vecs[8] = '{4'b0110, 2, 2,  1, 256'h0};
    for (int i = 1; i < 9; i++) vecs[i].dig = {8{32'hD0000000 | 32'(i)}};

    reset_i          = 1'b1;
    bus.req_v_i      = '0;
    bus.eng_done_i   = 1'b0;
    bus.eng_digest_i = '0;
    bus.resp_ready_i = '0;
    for (int k = 0; k < N; k++) bus.req_msg_i[k*MSG_W +: MSG_W] = msg_of(k);
    cyc();
    cyc();
    chk("rst_busy", 256'(bus.busy_o), 256'(0));
    chk("rst_msg", 256'(bus.msg_o), 256'(0));
    chk("rst_digest", bus.resp_digest_o, 256'(0));
    chk("rst_resp_v", 256'(bus.resp_v_o), 256'(0));
    chk("rst_start", 256'(bus.eng_start_o), 256'(0));
    reset_i = 1'b0;
    cyc();

`ifdef SHA256_ARB_WATCHDOG_EN
    bus.req_v_i = 4'b0010;
    #1;
    chk("wd_ready", 256'(bus.req_ready_o), 256'(4'b0010));
    cyc();
    bus.req_v_i = '0;
    cyc();
    for (int k = 1; k <= 8; k++) begin
      cyc();
      chk("wd_resp_v_early", 256'(bus.resp_v_o), 256'(0));
    end
    cyc();
    chk("wd_resp_v", 256'(bus.resp_v_o), 256'(4'b0010));
    chk("wd_timeout", 256'(bus.timeout_o), 256'(1));
    chk("wd_digest", bus.resp_digest_o, 256'(0));
    bus.resp_ready_i = 4'b0010;
    cyc();
    bus.resp_ready_i = '0;
    chk("wd_timeout_clr", 256'(bus.timeout_o), 256'(0));
    reset_i = 1'b1;
    cyc();
    reset_i = 1'b0;
    cyc();
`endif

    for (int i = 0; i < 9; i++) run_txn(vecs[i]);

    // Stray done in IDLE and in START must not advance the FSM.
    bus.req_v_i      = '0;
    bus.eng_done_i   = 1'b1;
    bus.eng_digest_i = 256'hDEAD;
    cyc();
    bus.eng_done_i = 1'b0;
    chk("stray_idle_busy", 256'(bus.busy_o), 256'(0));
    chk("stray_idle_resp", 256'(bus.resp_v_o), 256'(0));
    bus.req_v_i = 4'b0100;
    #1;
    chk("stray_ready", 256'(bus.req_ready_o), 256'(4'b0100));
    cyc();
    bus.req_v_i    = '0;
    bus.eng_done_i = 1'b1;
    cyc();
    bus.eng_done_i = 1'b0;
    chk("stray_start_busy", 256'(bus.busy_o), 256'(1));
    chk("stray_start_resp", 256'(bus.resp_v_o), 256'(0));
    cyc();
    chk("stray_still_busy", 256'(bus.resp_v_o), 256'(0));
    bus.eng_done_i   = 1'b1;
    bus.eng_digest_i = 256'h5A5A;
    cyc();
    bus.eng_done_i = 1'b0;
    chk("stray_resp_v", 256'(bus.resp_v_o), 256'(4'b0100));
    chk("stray_digest", bus.resp_digest_o, 256'h5A5A);
    bus.resp_ready_i = 4'b0100;
    cyc();
    bus.resp_ready_i = '0;

    // Reset while BUSY drops the message; a late done is ignored.
    bus.req_v_i = 4'b0001;
    #1;
    chk("rb_ready", 256'(bus.req_ready_o), 256'(4'b0001));
    cyc();
    bus.req_v_i = '0;
    cyc();
    chk("rb_in_busy", 256'(bus.busy_o), 256'(1));
    reset_i = 1'b1;
    #1;
    chk("rb_busy", 256'(bus.busy_o), 256'(0));
    chk("rb_msg", 256'(bus.msg_o), 256'(0));
    chk("rb_digest", bus.resp_digest_o, 256'(0));
    chk("rb_start", 256'(bus.eng_start_o), 256'(0));
    cyc();
    reset_i = 1'b0;
    cyc();
    bus.eng_done_i   = 1'b1;
    bus.eng_digest_i = 256'hBEEF;
    cyc();
    bus.eng_done_i = 1'b0;
    chk("rb_late_busy", 256'(bus.busy_o), 256'(0));
    chk("rb_late_resp", 256'(bus.resp_v_o), 256'(0));
    chk("rb_late_digest", bus.resp_digest_o, 256'(0));
    bus.req_v_i = 4'b1111;
    #1;
    chk("rb_prio", 256'(bus.req_ready_o), 256'(4'b0001));
    bus.req_v_i = '0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
